// File: rtl/pbit_local_field.sv
// Serial local-field engine feeding a p-bit: I = h + sum(J_j * s_j), one neighbour per
// cycle, saturated to a 7-bit signed bias with a one-cycle valid pulse.
module pbit_local_field #(
  parameter int N_NEIGH   = 8,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 12
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic [N_NEIGH-1:0]         m,
  input  logic [W_WIDTH-1:0]         h,
  input  logic                       w_we,
  input  logic [$clog2(N_NEIGH)-1:0] w_addr,
  input  logic [W_WIDTH-1:0]         w_data,
  output logic [6:0]                 z,
  output logic                       z_valid,
  output logic                       busy,
  output logic                       wr_drop
);

  localparam int AW = $clog2(N_NEIGH);
  localparam int EXT = ACC_WIDTH - W_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ZMax = ACC_WIDTH'(63);
  localparam logic signed [ACC_WIDTH-1:0] ZMin = ACC_WIDTH'(-64);

  typedef enum logic [1:0] {StIdle, StAccum, StClamp} state_e;

  state_e                       state_q;
  logic [W_WIDTH-1:0]           j_q [N_NEIGH];
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic [AW-1:0]                idx_q;
  logic [N_NEIGH-1:0]           m_snap_q;

  logic signed [ACC_WIDTH-1:0]  j_ext;
  logic signed [ACC_WIDTH-1:0]  h_ext;
  logic                         last_idx;

  // Sign-extend the current weight and the bias; negation happens at full accumulator width.
  always_comb begin
    j_ext    = {{EXT{j_q[idx_q][W_WIDTH-1]}}, j_q[idx_q]};
    h_ext    = {{EXT{h[W_WIDTH-1]}}, h};
    last_idx = (32'(idx_q) == N_NEIGH - 1);
  end

  // Weight bank: writes land only in idle; out-of-range addresses are dropped silently.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < N_NEIGH; i++) j_q[i] <= '0;
    end else if (w_we && state_q == StIdle && 32'(w_addr) < N_NEIGH) begin
      j_q[w_addr] <= w_data;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      idx_q    <= '0;
      m_snap_q <= '0;
      z        <= '0;
      z_valid  <= 1'b0;
      busy     <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      z_valid <= 1'b0;
      // A write attempted during an evaluation is rejected and flagged one cycle later.
      wr_drop <= w_we && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_snap_q <= m;
            acc_q    <= h_ext;
            idx_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StAccum;
          end
        end
        StAccum: begin
          if (m_snap_q[idx_q]) acc_q <= acc_q + j_ext;
          else                 acc_q <= acc_q - j_ext;
          if (last_idx) begin
            idx_q   <= '0;
            state_q <= StClamp;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        StClamp: begin
          if (acc_q > ZMax)      z <= 7'h3F;
          else if (acc_q < ZMin) z <= 7'h40;
          else                   z <= acc_q[6:0];
          z_valid <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_local_field.sv
// Scoreboard bench for pbit_local_field: stimulus pushes expected z, a monitor pops on z_valid.
module tb_pbit_local_field;

  logic       CLK;
  logic       RST;
  logic       start;
  logic [7:0] m;
  logic [7:0] h;
  logic       w_we;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic [6:0] z;
  logic       z_valid;
  logic       busy;
  logic       wr_drop;

  int         vec_count = 0;
  int         miscompares = 0;
  logic [6:0] exp_q [$];

  pbit_local_field #(.N_NEIGH(8), .W_WIDTH(8), .ACC_WIDTH(12)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .m       (m),
    .h       (h),
    .w_we    (w_we),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .z       (z),
    .z_valid (z_valid),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: every z_valid must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (z_valid) begin
      vec_count++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL z_valid_unexpected: got z=%h with no evaluation outstanding", z);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        if (z !== e) begin
          miscompares++;
          $display("FAIL z_result: got %h expected %h", z, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_count++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic write_w(input logic [2:0] a, input logic [7:0] d);
    @(negedge CLK);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(negedge CLK);
    w_we = 1'b0;
  endtask

  task automatic set_all_w(input logic [7:0] d);
    for (int i = 0; i < 8; i++) write_w(3'(i), d);
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic start_eval(input logic [7:0] mv, input logic [7:0] hv, input logic [6:0] e);
    @(negedge CLK);
    m = mv; h = hv; start = 1'b1;
    exp_q.push_back(e);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_timeout"}, 32'(n < 60), 32'd1);
    @(negedge CLK);
  endtask

  initial begin
    int cnt;
    RST = 1'b0; start = 1'b0; m = '0; h = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
    #12;
    check("rst_z", 32'(z), 32'h0);
    check("rst_z_valid", 32'(z_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wr_drop", 32'(wr_drop), 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    // All J=0, h=5; busy must last exactly 9 cycles.
    start_eval(8'hA5, 8'd5, 7'h05);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      cnt++;
      @(negedge CLK);
    end
    check("busy_cycles", 32'(cnt), 32'd9);
    wait_done("zero_w");

    // All J=+10, h=0.
    set_all_w(8'd10);
    start_eval(8'hFF, 8'd0, 7'h3F);
    wait_done("sat_pos");
    start_eval(8'h00, 8'd0, 7'h40);
    wait_done("sat_neg");
    start_eval(8'h0F, 8'd0, 7'h00);
    wait_done("balanced");

    // J[0]=-128, m=0, h=-60: -60 + 128 = 68 saturates high.
    set_all_w(8'd0);
    write_w(3'd0, 8'h80);
    start_eval(8'h00, 8'hC4, 7'h3F);
    wait_done("neg_min_w");

    // J[3]=-20, m=FF, h=7 -> -13; m toggled mid-evaluation must not matter.
    write_w(3'd0, 8'd0);
    write_w(3'd3, 8'hEC);
    start_eval(8'hFF, 8'd7, 7'h73);
    @(negedge CLK);
    m = 8'h00; h = 8'h40;
    wait_done("snapshot");

    // While busy: stray start is ignored, write to J[1] is dropped and flagged.
    start_eval(8'hFF, 8'd7, 7'h73);
    @(negedge CLK);
    start = 1'b1; w_we = 1'b1; w_addr = 3'd1; w_data = 8'd5;
    @(negedge CLK);
    start = 1'b0; w_we = 1'b0;
    check("wr_drop_pulse", 32'(wr_drop), 32'h1);
    @(negedge CLK);
    check("wr_drop_clear", 32'(wr_drop), 32'h0);
    wait_done("busy_start");
    start_eval(8'hFF, 8'd7, 7'h73);
    wait_done("j1_unchanged");

    // Reset at edge 4 of an evaluation aborts it without a result.
    start_eval(8'hFF, 8'd7, 7'h73);
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    exp_q.delete();
    #1;
    check("abort_z", 32'(z), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    repeat (12) @(negedge CLK);
    RST = 1'b1;
    // Weights were cleared by reset, so the result is h alone (-100 saturates low).
    start_eval(8'h3C, 8'h9C, 7'h40);
    wait_done("after_reset");
    write_w(3'd5, 8'hE2);
    start_eval(8'h00, 8'd10, 7'h28);
    wait_done("after_reset_w");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
